// File: rtl/mem_wb_if.sv
// MEM/WB stage bundle: MEM-stage result inputs, WB control, and register-file write port.
interface mem_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              mem_valid;
    logic              mem_wreg;
    logic              mem_is_load;
    logic [2:0]        mem_load_type;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_rdata;
    logic              wb_stall;
    logic              wb_flush;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_waddr;
    logic [DATA_W-1:0] wb_wdata;
    logic              wb_misalign;
    logic [31:0]       retire_cnt;

    modport master (
        output mem_valid, mem_wreg, mem_is_load, mem_load_type, mem_waddr,
               mem_alu_result, mem_rdata, wb_stall, wb_flush,
        input  wb_we, wb_waddr, wb_wdata, wb_misalign, retire_cnt
    );

    modport slave (
        input  mem_valid, mem_wreg, mem_is_load, mem_load_type, mem_waddr,
               mem_alu_result, mem_rdata, wb_stall, wb_flush,
        output wb_we, wb_waddr, wb_wdata, wb_misalign, retire_cnt
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, sub-word load formatter and retired-instruction counter.
// Optional macro WB_SUBWORD_LOAD_EN enables LB/LBU/LH/LHU lane selection and halfword misalign detection.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    mem_wb_if.slave  bus
);
    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;

    logic              valid_r;
    logic              wreg_r;
    logic              is_load_r;
    logic [2:0]        ltype_r;
    logic [ADDR_W-1:0] waddr_r;
    logic [DATA_W-1:0] alu_r;
    logic [DATA_W-1:0] rdata_r;
    logic [31:0]       retire_cnt_r;

    logic [DATA_W-1:0] load_data_s;
    logic              lw_like_s;
    logic              half_mis_s;

    // Pipeline register: flush squashes, stall holds, otherwise capture MEM inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r   <= 1'b0;
            wreg_r    <= 1'b0;
            is_load_r <= 1'b0;
            ltype_r   <= 3'd0;
            waddr_r   <= {ADDR_W{1'b0}};
            alu_r     <= {DATA_W{1'b0}};
            rdata_r   <= {DATA_W{1'b0}};
        end else if (bus.wb_flush) begin
            valid_r   <= 1'b0;
        end else if (!bus.wb_stall) begin
            valid_r   <= bus.mem_valid;
            wreg_r    <= bus.mem_wreg;
            is_load_r <= bus.mem_is_load;
            ltype_r   <= bus.mem_load_type;
            waddr_r   <= bus.mem_waddr;
            alu_r     <= bus.mem_alu_result;
            rdata_r   <= bus.mem_rdata;
        end
    end

    // Retire counter: the WB instruction retires when it leaves unstalled (wraps naturally).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_r <= 32'd0;
        end else if (valid_r && !bus.wb_stall) begin
            retire_cnt_r <= retire_cnt_r + 32'd1;
        end
    end

`ifdef WB_SUBWORD_LOAD_EN
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection from the effective-address low bits, little-endian.
    always_comb begin
        byte_s = 8'd0;
        case (alu_r[1:0])
            2'd0:    byte_s = rdata_r[7:0];
            2'd1:    byte_s = rdata_r[15:8];
            2'd2:    byte_s = rdata_r[23:16];
            2'd3:    byte_s = rdata_r[31:24];
            default: byte_s = rdata_r[7:0];
        endcase
        if (alu_r[1]) begin
            half_s = rdata_r[31:16];
        end else begin
            half_s = rdata_r[15:0];
        end
    end

    // Extension of the selected lane; unknown load types behave as LW.
    always_comb begin
        load_data_s = rdata_r;
        lw_like_s   = 1'b0;
        half_mis_s  = 1'b0;
        case (ltype_r)
            LT_LB:   load_data_s = {{(DATA_W-8){byte_s[7]}}, byte_s};
            LT_LBU:  load_data_s = {{(DATA_W-8){1'b0}}, byte_s};
            LT_LH:   begin
                load_data_s = {{(DATA_W-16){half_s[15]}}, half_s};
                half_mis_s  = alu_r[0];
            end
            LT_LHU:  begin
                load_data_s = {{(DATA_W-16){1'b0}}, half_s};
                half_mis_s  = alu_r[0];
            end
            default: begin
                load_data_s = rdata_r;
                lw_like_s   = 1'b1;
            end
        endcase
    end
`else
    // Without sub-word support every load returns the raw word; only word loads check alignment.
    always_comb begin
        load_data_s = rdata_r;
        half_mis_s  = 1'b0;
        case (ltype_r)
            LT_LB, LT_LBU, LT_LH, LT_LHU: lw_like_s = 1'b0;
            default:                      lw_like_s = 1'b1;
        endcase
    end
`endif

    assign bus.wb_we       = valid_r & wreg_r & (waddr_r != {ADDR_W{1'b0}});
    assign bus.wb_waddr    = waddr_r;
    assign bus.wb_wdata    = is_load_r ? load_data_s : alu_r;
    assign bus.wb_misalign = valid_r & is_load_r &
                             ((lw_like_s & (alu_r[1:0] != 2'd0)) | half_mis_s);
    assign bus.retire_cnt  = retire_cnt_r;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases plus randomized traffic against a reference model.
module tb_mem_wb_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    mem_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: the instruction currently sitting in WB.
    bit          m_valid;
    bit          m_wreg;
    bit          m_is_load;
    logic [2:0]  m_ltype;
    logic [4:0]  m_waddr;
    logic [31:0] m_alu;
    logic [31:0] m_rdata;
    logic [31:0] m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_wdata(bit is_load, logic [2:0] lt, logic [31:0] addr,
                                              logic [31:0] rd);
        int unsigned off;
        logic [31:0] v;
        if (!is_load) return addr;
`ifdef WB_SUBWORD_LOAD_EN
        if (lt == 3'd1 || lt == 3'd2) begin
            off = 32'(addr % 4);
            v   = (rd >> (8 * off)) & 32'h0000_00FF;
            if (lt == 3'd1 && v >= 32'd128) v = v - 32'd256;
            return v;
        end
        if (lt == 3'd3 || lt == 3'd4) begin
            off = 32'((addr / 2) % 2);
            v   = (rd >> (16 * off)) & 32'h0000_FFFF;
            if (lt == 3'd3 && v >= 32'd32768) v = v - 32'd65536;
            return v;
        end
`endif
        return rd;
    endfunction

    function automatic bit ref_misalign();
        bit word_load;
        bit half_load;
        word_load = !(m_ltype >= 3'd1 && m_ltype <= 3'd4);
        half_load = (m_ltype == 3'd3 || m_ltype == 3'd4);
        if (!(m_valid && m_is_load)) return 1'b0;
        if (word_load && (m_alu % 4) != 0) return 1'b1;
`ifdef WB_SUBWORD_LOAD_EN
        if (half_load && (m_alu % 2) != 0) return 1'b1;
`else
        if (half_load && 1'b0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_wreg = 0; m_is_load = 0; m_ltype = 3'd0;
        m_waddr = 5'd0; m_alu = 32'd0; m_rdata = 32'd0; m_cnt = 32'd0;
    endtask

    task automatic check_outputs();
        check_eq("we", {31'd0, bus.wb_we}, {31'd0, m_valid && m_wreg && (m_waddr != 5'd0)});
        check_eq("misalign", {31'd0, bus.wb_misalign}, {31'd0, ref_misalign()});
        check_eq("retire_cnt", bus.retire_cnt, m_cnt);
        if (m_valid) begin
            check_eq("waddr", {27'd0, bus.wb_waddr}, {27'd0, m_waddr});
            check_eq("wdata", bus.wb_wdata, ref_wdata(m_is_load, m_ltype, m_alu, m_rdata));
        end
    endtask

    // One clock: update the model at the edge from the inputs driven, then check at the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (m_valid && !bus.wb_stall) m_cnt = m_cnt + 32'd1;
        if (bus.wb_flush) begin
            m_valid = 0;
        end else if (!bus.wb_stall) begin
            m_valid   = bus.mem_valid;
            m_wreg    = bus.mem_wreg;
            m_is_load = bus.mem_is_load;
            m_ltype   = bus.mem_load_type;
            m_waddr   = bus.mem_waddr;
            m_alu     = bus.mem_alu_result;
            m_rdata   = bus.mem_rdata;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input bit v, input bit wr, input bit ld, input logic [2:0] lt,
                         input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] rd);
        bus.mem_valid = v; bus.mem_wreg = wr; bus.mem_is_load = ld; bus.mem_load_type = lt;
        bus.mem_waddr = wa; bus.mem_alu_result = alu; bus.mem_rdata = rd;
        bus.wb_stall = 1'b0; bus.wb_flush = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_we"}, {31'd0, bus.wb_we}, 32'd0);
        check_eq({tag, "_waddr"}, {27'd0, bus.wb_waddr}, 32'd0);
        check_eq({tag, "_wdata"}, bus.wb_wdata, 32'd0);
        check_eq({tag, "_misalign"}, {31'd0, bus.wb_misalign}, 32'd0);
        check_eq({tag, "_cnt"}, bus.retire_cnt, 32'd0);
    endtask

    logic [2:0]  sw_lt   [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [31:0] sw_addr [4] = '{32'h0000_0003, 32'h0000_0002, 32'h0000_0002, 32'h0000_0000};
`ifdef WB_SUBWORD_LOAD_EN
    logic [31:0] sw_exp  [4] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01};
`else
    logic [31:0] sw_exp  [4] = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
`endif

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
        model_reset();
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF);
        cycle();
        check_eq("alu_we", {31'd0, bus.wb_we}, 32'd1);
        check_eq("alu_wdata", bus.wb_wdata, 32'h1234_5678);
        check_eq("alu_cnt", bus.retire_cnt, 32'd0);

        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd0, 32'h0000_0042, 32'd0);
        cycle();
        check_eq("r0_we", {31'd0, bus.wb_we}, 32'd0);
        check_eq("r0_prev_retired", bus.retire_cnt, 32'd1);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1, sw_lt[i], 5'd9, sw_addr[i], 32'h80FF_7F01);
            cycle();
            check_eq("subword", bus.wb_wdata, sw_exp[i]);
        end

        drive(1'b1, 1'b1, 1'b1, 3'd0, 5'd3, 32'h0000_1002, 32'hCAFE_F00D);
        cycle();
        check_eq("lw_misalign", {31'd0, bus.wb_misalign}, 32'd1);
        check_eq("lw_misalign_data", bus.wb_wdata, 32'hCAFE_F00D);
        check_eq("lw_misalign_we", {31'd0, bus.wb_we}, 32'd1);

        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd12, 32'hA5A5_0001, 32'd0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd13, 32'h0BAD_0000 + 32'(i), 32'd0);
            bus.wb_stall = 1'b1;
            cycle();
            check_eq("stall_hold", bus.wb_wdata, 32'hA5A5_0001);
        end
        bus.wb_flush = 1'b1;
        cycle();
        check_eq("stall_flush_we", {31'd0, bus.wb_we}, 32'd0);

        drive(1'b1, 1'b0, 1'b0, 3'd0, 5'd1, 32'h0000_0010, 32'd0);
        cycle();
        bus.wb_stall = 1'b1;
        force dut.retire_cnt_r = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_r;
        m_cnt = 32'hFFFF_FFFF;
        check_eq("preload", bus.retire_cnt, 32'hFFFF_FFFF);
        bus.wb_stall = 1'b0;
        cycle();
        check_eq("wrap", bus.retire_cnt, 32'd0);

        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd7, 32'h7777_7777, 32'd0);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd8, 32'h8888_8888, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("async_rst");
        @(negedge clk);
        check_all_zero("rst_held");
        rst_n = 1'b1;

        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd4, 32'h4444_4444, 32'd0);
        cycle();
        bus.wb_stall = 1'b1;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("stall_rst");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
        cycle();
        check_eq("stall_rst_no_write", {31'd0, bus.wb_we}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  3'($urandom_range(0, 7)), 5'($urandom), $urandom, $urandom);
            bus.wb_stall = ($urandom_range(0, 3) == 0);
            bus.wb_flush = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
